flag_branch_unit: RTL and testbench
===================================

FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 Ports SHALL be, in this order:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ex_valid  input  1  ALU instruction present in EX this cycle.
- ex_stall  input  1  EX held this cycle; no flag commit.
- flush  input  1  cancel EX commit and any pending branch.
- alu_op  input  3  ALU opcode of EX instruction, same encoding as the CPU ALU.
- N_in, Z_in, V_in  input  1 each  ALU flag outputs for the EX instruction.
- br_req  input  1  branch resolution request from ID.
- br_cond  input  3  branch condition code.
- N, Z, V  output  1 each  architectural flag register.
- br_done  output  1  one-cycle pulse: branch resolved.
- br_taken  output  1  resolution result, qualified by br_done.
- br_busy  output  1  request accepted and not yet done.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-high.

Function
REQ-003 Flag commit SHALL occur when commit = ex_valid & ~ex_stall & ~flush.
REQ-004 The per-opcode update mask SHALL be:
- 000-011 (AND/OR/XOR/NOT): N,Z.
- 100 (ADD): N,Z,V.
- 101 (LSL), 110 (LSR/ASR): Z only.
- 111 (ROT): none.
Non-masked flags SHALL hold.
REQ-005 Flags SHALL update on the edge ending the commit cycle (1-cycle latency).
REQ-006 flags_next SHALL be the masked commit value when commit is high, else the current flags; branch evaluation SHALL use flags_next (bypass).
REQ-007 Hazard SHALL be defined as ex_valid & ex_stall & (mask of alu_op nonzero).
REQ-008 Condition codes SHALL be:
- 000 NEQ: ~Z
- 001 EQ: Z
- 010 GT: ~Z & ~N
- 011 LT: N
- 100 GTE: Z | ~N
- 101 LTE: N | Z
- 110 OVFL: V
- 111 UNCOND: 1
REQ-009 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-010 IDLE transitions SHALL be:
- br_req & ~flush & hazard: latch br_cond, go to WAIT.
- br_req & ~flush & ~hazard: latch br_cond, register taken from flags_next, go to DONE.
- Otherwise: stay in IDLE.
REQ-011 WAIT transitions SHALL be:
- flush: go to IDLE, no br_done.
- ~hazard: register taken from flags_next using the latched condition, go to DONE.
- Otherwise: stay in WAIT.
br_req and br_cond SHALL be ignored while in WAIT.
REQ-012 DONE SHALL last one cycle, then go to IDLE; br_req SHALL be ignored in DONE, so the maximum request rate is one per 2 cycles.
REQ-013 br_done SHALL equal (state==DONE) & ~flush.
REQ-014 br_taken SHALL be the registered result when br_done is high, else 0.
REQ-015 br_busy SHALL be high in WAIT and DONE.
REQ-016 Simultaneous br_req and commit SHALL resolve on the committed flags, with no stall.
REQ-017 flush SHALL have priority over commit and over every FSM transition.

Reset
REQ-018 While rst is high: N=Z=V=0, state=IDLE, br_done=br_taken=br_busy=0, latched condition=000.
REQ-019 Reset deasserted mid-WAIT or mid-DONE SHALL leave no br_done pulse.

Verification
REQ-020 ADD with N_in=1, Z_in=0, V_in=1, commit -> next cycle N=1, Z=0, V=1; then ROT commit with all flag inputs 0 -> flags unchanged.
REQ-021 Flags N=0, Z=0; EX LSL commit with Z_in=1 and br_req with cond 001 in the same cycle -> br_done=1, br_taken=1 next cycle; N unchanged.
REQ-022 ADD in EX with ex_stall=1 for 3 cycles, br_req cond 011 -> br_busy high, WAIT held 3 cycles; after the commit with N_in=1, br_done=1 and br_taken=1 exactly one cycle later.
REQ-023 br_req held high continuously, cond 111, no hazard -> br_done pulses every 2nd cycle, br_taken=1 on each pulse.
REQ-024 Flush asserted in WAIT and in DONE -> no br_done, state IDLE next cycle, flags not updated by the flushed instruction.
REQ-025 rst asserted asynchronously mid-WAIT with flags nonzero -> all outputs 0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/flag_branch_unit.sv
// -----------------------------------------------------------------------------
// flag_branch_unit
//   Holds the architectural N/Z/V flag register and resolves conditional
//   branches against it. Flag writes from the EX stage are masked per ALU
//   opcode; branch evaluation sees the flags the EX instruction is writing
//   this very cycle (bypass), and waits while a flag-writing instruction is
//   stalled in EX.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   ex_valid, ex_stall  EX instruction present / held this cycle
//   flush               cancels the EX flag commit and any pending branch
//   alu_op              ALU opcode of the EX instruction
//   N_in, Z_in, V_in    flags produced by the EX instruction
//   br_req, br_cond     branch resolution request and condition code
//   N, Z, V             architectural flags
//   br_done             one-cycle pulse: branch resolved
//   br_taken            resolution result, valid only with br_done
//   br_busy             request accepted and not yet done
// -----------------------------------------------------------------------------
module flag_branch_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic       ex_valid,
   input  logic       ex_stall,
   input  logic       flush,
   input  logic [2:0] alu_op,
   input  logic       N_in,
   input  logic       Z_in,
   input  logic       V_in,
   input  logic       br_req,
   input  logic [2:0] br_cond,
   output logic       N,
   output logic       Z,
   output logic       V,
   output logic       br_done,
   output logic       br_taken,
   output logic       br_busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

   state_t     state_q;
   logic [2:0] cond_q;
   logic       taken_q;
   logic       n_q, z_q, v_q;
   logic       n_d, z_d, v_d;
   logic [2:0] upd_mask;     // {N, Z, V} write enables for alu_op
   logic       commit;
   logic       hazard;

   // Which flags each opcode writes, packed as {N, Z, V}.
   function automatic logic [2:0] mask_of(input logic [2:0] op);
      logic [2:0] m;
      m = 3'b000;
      case (op)
         3'b000, 3'b001, 3'b010, 3'b011: m = 3'b110;   // logic ops
         3'b100:                         m = 3'b111;   // ADD
         3'b101, 3'b110:                 m = 3'b010;   // shifts
         default:                        m = 3'b000;   // ROT
      endcase
      return m;
   endfunction

   function automatic logic cond_true(input logic [2:0] c, input logic fn,
                                      input logic fz, input logic fv);
      logic t;
      t = 1'b0;
      case (c)
         3'b000:  t = ~fz;
         3'b001:  t = fz;
         3'b010:  t = ~fz & ~fn;
         3'b011:  t = fn;
         3'b100:  t = fz | ~fn;
         3'b101:  t = fn | fz;
         3'b110:  t = fv;
         default: t = 1'b1;
      endcase
      return t;
   endfunction

   always_comb begin
      upd_mask = mask_of(alu_op);
      commit   = ex_valid & ~ex_stall & ~flush;
      // A stalled instruction that will write flags makes the current flags
      // stale for branch purposes.
      hazard   = ex_valid & ex_stall & (|upd_mask);
      n_d      = (commit & upd_mask[2]) ? N_in : n_q;
      z_d      = (commit & upd_mask[1]) ? Z_in : z_q;
      v_d      = (commit & upd_mask[0]) ? V_in : v_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_q <= 1'b0;
         z_q <= 1'b0;
         v_q <= 1'b0;
      end else begin
         n_q <= n_d;
         z_q <= z_d;
         v_q <= v_d;
      end
   end

   // Branch FSM; evaluation uses n_d/z_d/v_d so a same-cycle commit is seen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cond_q  <= 3'b000;
         taken_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (br_req && !flush) begin
                  cond_q <= br_cond;
                  if (hazard) begin
                     state_q <= ST_WAIT;
                  end else begin
                     taken_q <= cond_true(br_cond, n_d, z_d, v_d);
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_WAIT: begin
               if (flush) begin
                  state_q <= ST_IDLE;
               end else if (!hazard) begin
                  taken_q <= cond_true(cond_q, n_d, z_d, v_d);
                  state_q <= ST_DONE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign N        = n_q;
   assign Z        = z_q;
   assign V        = v_q;
   // A flush in the DONE cycle suppresses the pulse itself.
   assign br_done  = (state_q == ST_DONE) & ~flush;
   assign br_taken = br_done & taken_q;
   assign br_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_flag_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_flag_branch_unit
//   Scoreboard bench: each driven cycle pushes the expected outputs from a
//   behavioural model; the entry is popped and compared on the falling edge.
//   A few fixed-value checks pin down the directed scenarios and async reset.
// -----------------------------------------------------------------------------
module tb_flag_branch_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       ex_valid, ex_stall, flush;
   logic [2:0] alu_op;
   logic       N_in, Z_in, V_in;
   logic       br_req;
   logic [2:0] br_cond;
   logic       N, Z, V, br_done, br_taken, br_busy;

   int n_vec = 0;
   int n_err = 0;

   logic [5:0] exp_q[$];

   // behavioural model state: 0 idle, 1 waiting, 2 done
   bit       m_n, m_z, m_v;
   int       m_st;
   bit [2:0] m_cond;
   bit       m_tak;

   always #5 clk = ~clk;

   flag_branch_unit dut (
      .clk      (clk),
      .rst      (rst),
      .ex_valid (ex_valid),
      .ex_stall (ex_stall),
      .flush    (flush),
      .alu_op   (alu_op),
      .N_in     (N_in),
      .Z_in     (Z_in),
      .V_in     (V_in),
      .br_req   (br_req),
      .br_cond  (br_cond),
      .N        (N),
      .Z        (Z),
      .V        (V),
      .br_done  (br_done),
      .br_taken (br_taken),
      .br_busy  (br_busy)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   // {N, Z, V} written by each opcode
   function automatic bit [2:0] fmask(input bit [2:0] op);
      if (op <= 3'd3) return 3'b110;
      if (op == 3'd4) return 3'b111;
      if (op == 3'd7) return 3'b000;
      return 3'b010;
   endfunction

   function automatic bit ceval(input bit [2:0] c, input bit n, input bit z, input bit v);
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return z || !n;
         3'd5: return n || z;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   task automatic model_reset();
      m_n = 0; m_z = 0; m_v = 0; m_st = 0; m_cond = 3'd0; m_tak = 0;
      exp_q.delete();
   endtask

   // One clock cycle: drive at posedge+1, compare at negedge, advance model.
   task automatic step(input string tag, input bit v, input bit s, input bit f,
                       input bit [2:0] op, input bit ni, input bit zi, input bit vi,
                       input bit req, input bit [2:0] c);
      bit [2:0]   m;
      bit         com, haz, fn, fz, fv;
      logic [5:0] g, e;
      ex_valid = v; ex_stall = s; flush = f; alu_op = op;
      N_in = ni; Z_in = zi; V_in = vi; br_req = req; br_cond = c;
      m   = fmask(op);
      com = v && !s && !f;
      haz = v && s && (m != 3'b000);
      fn  = (com && m[2]) ? ni : m_n;
      fz  = (com && m[1]) ? zi : m_z;
      fv  = (com && m[0]) ? vi : m_v;
      exp_q.push_back({m_n, m_z, m_v, (m_st == 2) && !f,
                       (m_st == 2) && !f && m_tak, m_st != 0});
      @(negedge clk);
      g = {N, Z, V, br_done, br_taken, br_busy};
      e = exp_q.pop_front();
      chk(tag, {2'b00, g}, {2'b00, e});
      @(posedge clk);
      case (m_st)
         0: if (req && !f) begin
               m_cond = c;
               if (haz) m_st = 1;
               else begin m_tak = ceval(c, fn, fz, fv); m_st = 2; end
            end
         1: if (f) m_st = 0;
            else if (!haz) begin m_tak = ceval(m_cond, fn, fz, fv); m_st = 2; end
         default: m_st = 0;
      endcase
      m_n = fn; m_z = fz; m_v = fv;
      #1;
   endtask

   task automatic idle(input string tag);
      step(tag, 0, 0, 0, 3'd0, 0, 0, 0, 0, 3'd0);
   endtask

   initial begin
      rst = 1'b1;
      ex_valid = 0; ex_stall = 0; flush = 0; alu_op = 3'd0;
      N_in = 0; Z_in = 0; V_in = 0; br_req = 0; br_cond = 3'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", {2'b00, N, Z, V, br_done, br_taken, br_busy}, 8'h00);
      rst = 1'b0;

      // ADD writes all three flags, ROT writes none
      step("add_commit", 1, 0, 0, 3'd4, 1, 0, 1, 0, 3'd0);
      step("rot_commit", 1, 0, 0, 3'd7, 0, 0, 0, 0, 3'd0);
      chk("rot_holds_nzv", {5'b0, N, Z, V}, 8'h05);

      // clear N,Z with AND, then LSL sets Z with a same-cycle EQ branch
      step("and_clear", 1, 0, 0, 3'd0, 0, 0, 0, 0, 3'd0);
      step("lsl_bypass_eq", 1, 0, 0, 3'd5, 1, 1, 0, 1, 3'd1);
      chk("bypass_n_z_done_taken", {4'b0, N, Z, br_done, br_taken}, 8'h07);
      idle("after_bypass");

      // branch waits while a stalled ADD holds EX
      step("stall_req_lt", 1, 1, 0, 3'd4, 0, 0, 0, 1, 3'd3);
      step("stall2", 1, 1, 0, 3'd4, 0, 0, 0, 0, 3'd0);
      step("stall3", 1, 1, 0, 3'd4, 0, 0, 0, 0, 3'd0);
      chk("wait_busy", {7'b0, br_busy}, 8'h01);
      step("stall_release", 1, 0, 0, 3'd4, 1, 0, 0, 0, 3'd0);
      chk("lt_done_taken", {6'b0, br_done, br_taken}, 8'h03);
      idle("after_wait");

      // back-to-back unconditional requests: pulse every other cycle
      for (int i = 0; i < 8; i++) step("uncond_stream", 0, 0, 0, 3'd0, 0, 0, 0, 1, 3'd7);
      idle("after_stream");

      // flush in WAIT: back to idle, flushed ADD does not write flags
      step("fw_req", 1, 1, 0, 3'd4, 0, 0, 0, 1, 3'd0);
      step("fw_flush", 1, 0, 1, 3'd4, 1, 1, 1, 0, 3'd0);
      step("fw_after", 0, 0, 0, 3'd0, 0, 0, 0, 0, 3'd0);
      chk("fw_idle", {7'b0, br_busy}, 8'h00);
      // flush in DONE: pulse suppressed, flushed ADD does not write flags
      step("fd_req", 0, 0, 0, 3'd0, 0, 0, 0, 1, 3'd7);
      step("fd_flush", 1, 0, 1, 3'd4, 1, 1, 1, 0, 3'd0);
      step("fd_after", 0, 0, 0, 3'd0, 0, 0, 0, 0, 3'd0);

      // every condition code against a bypassed ADD result
      for (int c = 0; c < 8; c++) begin
         step("cond_sweep", 1, 0, 0, 3'd4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1, 3'(c));
         idle("cond_result");
      end

      // random traffic
      for (int i = 0; i < 60; i++) begin
         step("random", 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
              $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end
      step("settle", 0, 0, 1, 3'd0, 0, 0, 0, 0, 3'd0);
      idle("settle2");

      // asynchronous reset while waiting with nonzero flags
      step("ar_set_flags", 1, 0, 0, 3'd4, 1, 0, 1, 0, 3'd0);
      step("ar_req", 1, 1, 0, 3'd4, 0, 0, 0, 1, 3'd3);
      #2 rst = 1'b1;
      #1 chk("async_reset_out", {2'b00, N, Z, V, br_done, br_taken, br_busy}, 8'h00);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      step("ar_release", 1, 0, 0, 3'd4, 0, 0, 0, 0, 3'd0);
      idle("ar_no_done");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
